// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MIPS single-port memory arbiter:
//   - default address / data widths of the shared 1024 x 32 memory
//   - owner tag recording which port is waiting for read data
//   - arbitration FSM states
//   - helper that maps a read grant onto an owner tag
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int MEM_ADDR_W     = 10;
    localparam int MEM_DATA_W     = 32;
    localparam int MEM_STARVE_LIM = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_H    = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } owner_e;

    typedef enum logic {
        ARB_NORMAL  = 1'b0,
        ARB_I_BOOST = 1'b1
    } arb_state_e;

    // Owner of the read issued this cycle; writes and idle cycles own nothing.
    function automatic owner_e read_owner(input logic h_rd, input logic d_rd,
                                          input logic i_rd);
        owner_e own;
        if (h_rd) begin
            own = OWN_H;
        end else if (d_rd) begin
            own = OWN_D;
        end else if (i_rd) begin
            own = OWN_I;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/mips_starve_ctr.sv
// ---------------------------------------------------------------------------
// mips_starve_ctr
// Counts consecutive cycles the instruction port is denied while requesting
// and raises a one-cycle boost when the count reaches STARVE_LIM.
// Ports:
//   clk1, rst_n   clock / async active-low reset
//   i_req, i_gnt  instruction port request and grant
//   host_lock     host-only mode; denial under lock does not count
//   boost         registered, 1 while the FSM is in ARB_I_BOOST
//   starve_cnt    current starvation count
// ---------------------------------------------------------------------------
module mips_starve_ctr
    import mips_mem_pkg::*;
#(
    parameter int STARVE_LIM = MEM_STARVE_LIM,
    localparam int CNT_W     = $clog2(STARVE_LIM + 1)
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic             i_gnt,
    input  logic             host_lock,
    output logic             boost,
    output logic [CNT_W-1:0] starve_cnt
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    arb_state_e       state_r;

    // Next count: clear on grant, idle or lock; saturate at the limit.
    always_comb begin
        cnt_next_s = cnt_r;
        if (host_lock || !i_req || i_gnt) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r == LIM) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and boost FSM; boost lasts exactly one cycle.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ARB_NORMAL;
        end else begin
            cnt_r <= cnt_next_s;
            case (state_r)
                ARB_NORMAL: begin
                    if (cnt_next_s == LIM) begin
                        state_r <= ARB_I_BOOST;
                    end else begin
                        state_r <= ARB_NORMAL;
                    end
                end
                ARB_I_BOOST: state_r <= ARB_NORMAL;
                default:     state_r <= ARB_NORMAL;
            endcase
        end
    end

    assign boost      = (state_r == ARB_I_BOOST);
    assign starve_cnt = cnt_r;

endmodule

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
// Shares one synchronous single-port memory between the host port (H), the
// MEM-stage data port (D) and the IF-stage instruction port (I).
// Ports:
//   clk1, rst_n                     clock / async active-low reset
//   host_lock                       only H may be granted while 1
//   {h,d,i}_req, {h,d}_we,          requests, write strobes,
//   {h,d,i}_addr, {h,d}_wdata       addresses and write data
//   {h,d,i}_gnt                     combinational grants (at most one)
//   {h,d,i}_rvalid, rdata           registered read return, 1-cycle latency
//   stall_if                        I requesting but not granted
//   mem_en/we/addr/wdata, mem_rdata memory macro interface
// ---------------------------------------------------------------------------
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_LIM = MEM_STARVE_LIM
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              host_lock,
    input  logic              h_req,
    input  logic              d_req,
    input  logic              i_req,
    input  logic              h_we,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              h_gnt,
    output logic              d_gnt,
    output logic              i_gnt,
    output logic              h_rvalid,
    output logic              d_rvalid,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              stall_if,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    logic             boost;
    // Count is kept for debug visibility; arbitration only needs boost.
    logic [CNT_W-1:0] starve_cnt_unused;
    logic             h_gnt_s;
    logic             d_gnt_s;
    logic             i_gnt_s;
    owner_e           owner_r;

    mips_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve_ctr (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_gnt      (i_gnt_s),
        .host_lock  (host_lock),
        .boost      (boost),
        .starve_cnt (starve_cnt_unused)
    );

    // Fixed-priority grant: H>D>I normally, I>H>D in boost; lock admits H only.
    always_comb begin
        h_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        i_gnt_s = 1'b0;
        if (!rst_n) begin
            h_gnt_s = 1'b0;
        end else if (boost) begin
            i_gnt_s = i_req & ~host_lock;
            h_gnt_s = h_req & ~i_gnt_s;
            d_gnt_s = d_req & ~host_lock & ~i_gnt_s & ~h_req;
        end else begin
            h_gnt_s = h_req;
            d_gnt_s = d_req & ~host_lock & ~h_req;
            i_gnt_s = i_req & ~host_lock & ~h_req & ~d_req;
        end
    end

    // Memory command mux from the single granted port; I never writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (h_gnt_s) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (d_gnt_s) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt_s) begin
            mem_we    = 1'b0;
            mem_addr  = i_addr;
            mem_wdata = {DATA_W{1'b0}};
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Owner tag of the read in flight; reset drops any pending return.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= read_owner(h_gnt_s & ~h_we, d_gnt_s & ~d_we, i_gnt_s);
        end
    end

    assign h_gnt    = h_gnt_s;
    assign d_gnt    = d_gnt_s;
    assign i_gnt    = i_gnt_s;
    assign mem_en   = h_gnt_s | d_gnt_s | i_gnt_s;
    assign stall_if = i_req & ~i_gnt_s;
    assign h_rvalid = (owner_r == OWN_H);
    assign d_rvalid = (owner_r == OWN_D);
    assign i_rvalid = (owner_r == OWN_I);
    assign rdata    = mem_rdata;

endmodule
